instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, meaning the instruction word width.
REQ-002 The module SHALL have parameter NB_BYTE, default 8, meaning the width of the incoming byte stream.
REQ-003 The module SHALL have parameter NB_ADDR, default 8, meaning the instruction memory word-address width (256 words).
REQ-004 The module SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the end-of-program instruction.
REQ-005 The module SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port start, input, 1 bit: a one-cycle request to begin a program load.
REQ-008 The module SHALL have port rx_data, input, NB_BYTE bits: the received program byte.
REQ-009 The module SHALL have port rx_valid, input, 1 bit: a one-cycle strobe that qualifies rx_data.
REQ-010 The module SHALL have port mem_write_en, output, 1 bit: the instruction memory write strobe.
REQ-011 The module SHALL have port mem_addr, output, NB_ADDR bits: the instruction memory word address.
REQ-012 The module SHALL have port mem_data, output, NB_DATA bits: the assembled instruction word.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-014 The module SHALL have port done, output, 1 bit: a level that is high after load completion until the next start.
REQ-015 The module SHALL have port overflow, output, 1 bit: high if memory filled before HALT_WORD arrived.
REQ-016 The module SHALL have port word_count, output, NB_ADDR+1 bits: the number of words written in the current or last load.

Function
REQ-017 The module SHALL implement the FSM states IDLE, COLLECT, WRITE and DONE.
REQ-018 IDLE SHALL move to COLLECT on start=1, clearing the byte index, write pointer, word_count, done and overflow.
REQ-019 COLLECT SHALL, on each rx_valid=1, place rx_data MSB-first (byte 0 -> [31:24], byte 3 -> [7:0]) and increment the 2-bit byte index.
REQ-020 COLLECT SHALL, on the rx_valid that completes byte 3, go to WRITE on the next edge.
REQ-021 WRITE SHALL last exactly one cycle, with mem_write_en=1, mem_addr=write pointer and mem_data=assembled word.
REQ-022 Write latency SHALL be that mem_write_en is asserted in the cycle immediately after the 4th byte is sampled.
REQ-023 mem_data and mem_addr SHALL hold their last values outside WRITE, and mem_write_en SHALL be 0 outside WRITE.
REQ-024 In WRITE the write pointer and word_count SHALL increment by 1 at the end of the cycle.
REQ-025 WRITE SHALL go to DONE if the word equals HALT_WORD (the halt word is itself written).
REQ-026 Otherwise, WRITE SHALL go to DONE with overflow=1 if the pointer written was 2**NB_ADDR-1.
REQ-027 Otherwise, WRITE SHALL return to COLLECT.
REQ-028 A rx_valid arriving during WRITE SHALL be accepted as byte 0 of the next word; no byte is dropped back-to-back.
REQ-029 rx_valid SHALL be ignored in IDLE and DONE.
REQ-030 start SHALL be ignored in COLLECT and WRITE.
REQ-031 start in DONE SHALL behave as in IDLE, i.e. restart the load from address 0.
REQ-032 busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-033 done SHALL be 1 exactly in DONE.
REQ-034 A partial word (fewer than 4 bytes) SHALL never be written.
REQ-035 The write pointer SHALL not wrap; overflow termination occurs before wrap.

Reset
REQ-036 While reset_n=0 the module SHALL be in state IDLE, independent of clock.
REQ-037 While reset_n=0 the outputs SHALL be: mem_write_en=0, mem_addr=0, mem_data=0, busy=0, done=0, overflow=0, word_count=0.
REQ-038 While reset_n=0 the byte index and write pointer SHALL be 0.
REQ-039 Reset asserted mid-load (including during WRITE) SHALL abort the load with no further write strobe; after release the block waits in IDLE for start.

Verification
REQ-040 The bench SHALL cover: start, then bytes 20,01,00,05 then FF,FF,FF,FF -> writes addr0=32'h20010005 and addr1=32'hFFFFFFFF; done=1; word_count=2; overflow=0.
REQ-041 The bench SHALL cover: bytes on consecutive cycles, with the 5th byte arriving during WRITE -> no byte lost; the second word is assembled correctly.
REQ-042 The bench SHALL cover: NB_ADDR=2, 4 non-halt words -> 4 writes at addr 0..3; done=1; overflow=1; word_count=4.
REQ-043 The bench SHALL cover: rx_valid pulses before start and after done -> no writes; word_count unchanged.
REQ-044 The bench SHALL cover: reset_n low after 2 bytes of a word, then a new load -> first write goes to addr0 with only the new bytes.
REQ-045 The bench SHALL cover: start pulsed while busy -> ignored; the load continues uninterrupted.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-stream program loader: packs MSB-first bytes into words
// and writes them to instruction memory until the halt word or full.
module instruction_loader #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [NB_BYTE-1:0] rx_data,
  input  logic               rx_valid,
  output logic               mem_write_en,
  output logic [NB_ADDR-1:0] mem_addr,
  output logic [NB_DATA-1:0] mem_data,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [NB_ADDR:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [NB_ADDR:0]   wc_q, wc_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               ovf_q, ovf_d;
  logic [NB_DATA-1:0] shift_w;

  assign shift_w = {word_q[NB_DATA-NB_BYTE-1:0], rx_data};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COLLECT;
          idx_d   = '0;
          wc_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          word_d = shift_w;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = wc_q[NB_ADDR-1:0];
            data_d  = shift_w;
          end
        end
      end
      WRITE: begin
        wc_d = wc_q + 1'b1;
        // a byte here is byte 0 of the next word
        if (rx_valid) begin
          word_d = shift_w;
          idx_d  = idx_q + 2'd1;
        end
        if (data_q == HALT_WORD) begin
          state_d = DONE;
        end else if (&addr_q) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wc_q    <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_write_en = (state_q == WRITE);
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign busy         = (state_q == COLLECT) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign overflow     = ovf_q;
  assign word_count   = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: default build plus
// a 4-word memory build for the overflow path.
module tb_instruction_loader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start_a, start_b;
  logic       rx_valid_a, rx_valid_b;
  logic [7:0] rx_data;

  logic        we_a, busy_a, done_a, ovf_a;
  logic [7:0]  addr_a;
  logic [31:0] data_a;
  logic [8:0]  wc_a;

  logic        we_b, busy_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int errors = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [63:0] e_a, e_b;

  always #5 clock = ~clock;

  instruction_loader u_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .rx_data(rx_data), .rx_valid(rx_valid_a),
    .mem_write_en(we_a), .mem_addr(addr_a), .mem_data(data_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a),
    .word_count(wc_a)
  );

  instruction_loader #(.NB_ADDR(2)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .rx_data(rx_data), .rx_valid(rx_valid_b),
    .mem_write_en(we_b), .mem_addr(addr_b), .mem_data(data_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .word_count(wc_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (we_a) begin
      chk("a_wr_pending", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        chk("a_wr", {32'(addr_a), data_a}, e_a);
      end
    end
    if (we_b) begin
      chk("b_wr_pending", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        chk("b_wr", {32'(addr_b), data_b}, e_b);
      end
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b,
                           input bit gap);
    rx_data = b;
    if (sel) rx_valid_b = 1'b1;
    else     rx_valid_a = 1'b1;
    @(posedge clock); #1;
    if (gap) begin
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w,
                           input bit gap, input bit push,
                           input logic [31:0] addr);
    if (push) begin
      if (sel) q_b.push_back({addr, w});
      else     q_a.push_back({addr, w});
    end
    for (int i = 3; i >= 0; i--) send_byte(sel, w[8*i +: 8], gap);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    for (int i = 0; i < 64; i++) begin
      if ((sel ? done_b : done_a) === 1'b1) break;
      @(posedge clock); #1;
    end
    chk(tag, 64'(sel ? done_b : done_a), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    rx_data    = '0;
    #12;
    chk("rst_we", 64'(we_a), 64'd0);
    chk("rst_addr", 64'(addr_a), 64'd0);
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_wc", 64'(wc_a), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // bytes before start are ignored
    send_word(0, 32'hDEADBEEF, 1, 0, 0);
    chk("idle_wc", 64'(wc_a), 64'd0);
    chk("idle_busy", 64'(busy_a), 64'd0);

    // basic load with halt word
    pulse_start(0);
    chk("start_busy", 64'(busy_a), 64'd1);
    send_word(0, 32'h20010005, 1, 1, 0);
    send_word(0, 32'hFFFFFFFF, 1, 1, 1);
    wait_done(0, "basic_done");
    chk("basic_wc", 64'(wc_a), 64'd2);
    chk("basic_ovf", 64'(ovf_a), 64'd0);
    chk("basic_busy", 64'(busy_a), 64'd0);
    chk("hold_addr", 64'(addr_a), 64'd1);
    chk("hold_data", 64'(data_a), 64'hFFFFFFFF);

    // bytes after done are ignored
    send_word(0, 32'h12345678, 1, 0, 0);
    chk("after_done_wc", 64'(wc_a), 64'd2);
    chk("after_done_done", 64'(done_a), 64'd1);

    // back-to-back bytes, restart from DONE
    pulse_start(0);
    send_word(0, 32'h11223344, 0, 1, 0);
    send_word(0, 32'hA5B6C7D8, 0, 1, 1);
    send_word(0, 32'hFFFFFFFF, 0, 1, 2);
    rx_valid_a = 1'b0;
    wait_done(0, "b2b_done");
    chk("b2b_wc", 64'(wc_a), 64'd3);

    // start while busy is ignored
    pulse_start(0);
    send_word(0, 32'h0BADF00D, 1, 1, 0);
    pulse_start(0);
    chk("start_busy_wc", 64'(wc_a), 64'd1);
    send_byte(0, 8'h55, 1);
    pulse_start(0);
    send_byte(0, 8'h66, 1);
    send_byte(0, 8'h77, 1);
    q_a.push_back({32'd1, 32'h55667788});
    send_byte(0, 8'h88, 1);
    send_word(0, 32'hFFFFFFFF, 1, 1, 2);
    wait_done(0, "ign_done");
    chk("ign_wc", 64'(wc_a), 64'd3);

    // reset mid-word aborts, new load starts at address 0
    pulse_start(0);
    send_byte(0, 8'hAA, 1);
    send_byte(0, 8'hBB, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_wc", 64'(wc_a), 64'd0);
    chk("mid_rst_data", 64'(data_a), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_busy", 64'(busy_a), 64'd0);
    pulse_start(0);
    send_word(0, 32'h01020304, 1, 1, 0);
    send_word(0, 32'hFFFFFFFF, 1, 1, 1);
    wait_done(0, "rst_load_done");
    chk("rst_load_wc", 64'(wc_a), 64'd2);

    // small memory fills before halt
    pulse_start(1);
    for (int i = 0; i < 4; i++)
      send_word(1, 32'hC0DE0000 + i, 1, 1, i);
    wait_done(1, "ovf_done");
    chk("ovf_flag", 64'(ovf_b), 64'd1);
    chk("ovf_wc", 64'(wc_b), 64'd4);
    send_word(1, 32'h99999999, 1, 0, 0);
    chk("ovf_after_wc", 64'(wc_b), 64'd4);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_a_empty", 64'(q_a.size()), 64'd0);
    chk("sb_b_empty", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
